// File: rtl/dso100_rgb565_video_capture.sv
// RGB565 parallel video capture into AXI4-Stream (TUSER = start of frame, TLAST = end of line).
// Input register -> one-pixel hold stage (supplies TLAST look-ahead) -> FIFO -> registered AXIS output.
// Measures the active geometry of each frame; the result is published on every vsync rising edge.
module dso100_rgb565_video_capture #(
    parameter int SYNC_POL   = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [15:0]      HD_D,
    input  logic             HD_DE,
    input  logic             HD_HSYNC,
    input  logic             HD_VSYNC,
    output logic [31:0]      M_AXIS_TDATA,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic             M_AXIS_TUSER,
    output logic             M_AXIS_TLAST,
    output logic [CNT_W-1:0] FRAME_WIDTH,
    output logic [CNT_W-1:0] FRAME_HEIGHT,
    output logic             FRAME_DONE,
    output logic             OVERFLOW,
    input  logic             CLR_OVF
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic           SYNC_INV = (SYNC_POL == 0);
    localparam logic [AW:0]    DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_VS, ARMED, ACTIVE} state_t;

    logic [1:0]       rst_pipe;
    logic             rst_sync_n;
    logic [15:0]      s1_d;
    logic             s1_de, s1_hs, s1_vs;
    logic             vs_prev, de_prev;
    logic             vs_rise, de_fall;
    logic [23:0]      px24;
    state_t           state, state_nxt;
    logic             load;
    logic             hold_valid, hold_user;
    logic [23:0]      hold_data;
    logic             full, ovf_evt, mem_wr, mem_rd;
    logic [25:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      mem_cnt, occ;
    logic             out_valid, out_user, out_last;
    logic [23:0]      out_data;
    logic [CNT_W-1:0] pix_cnt, last_width, line_cnt;
    logic             sync_unused;

    // Reset synchronizer: asynchronous assertion, release aligned to CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    // Stage 1: register the bus and normalise syncs to active-high.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            s1_d    <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            vs_prev <= 1'b0;
            de_prev <= 1'b0;
        end else begin
            s1_d    <= HD_D;
            s1_de   <= HD_DE;
            s1_hs   <= HD_HSYNC ^ SYNC_INV;
            s1_vs   <= HD_VSYNC ^ SYNC_INV;
            vs_prev <= s1_vs;
            de_prev <= s1_de;
        end
    end

    // Line structure comes from DE; HSYNC is captured but not otherwise needed.
    assign sync_unused = s1_hs;
    assign vs_rise     = s1_vs & ~vs_prev;
    assign de_fall     = ~s1_de & de_prev;
    assign px24        = {s1_d[15:11], s1_d[15:13], s1_d[10:5], s1_d[10:9], s1_d[4:0], s1_d[4:2]};

    // The held pixel is written every cycle it is valid; overflow is judged on occupancy before any read.
    assign occ     = mem_cnt + {{AW{1'b0}}, out_valid};
    assign full    = (occ == DEPTH_V);
    assign ovf_evt = hold_valid & full;
    assign mem_wr  = hold_valid & ~full;
    assign mem_rd  = (mem_cnt != '0) & (~out_valid | M_AXIS_TREADY);

    // Capture FSM: next state and hold-stage load enable.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            WAIT_VS: if (vs_rise) state_nxt = ARMED;
            ARMED: begin
                if (s1_de) begin
                    load      = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                load = s1_de;
                if (vs_rise) state_nxt = ARMED;
            end
            default: state_nxt = WAIT_VS;
        endcase
        if (ovf_evt) begin
            state_nxt = WAIT_VS;
            load      = 1'b0;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= WAIT_VS;
        else             state <= state_nxt;
    end

    // Stage 2: hold the latest captured pixel until the following sample decides TLAST.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            hold_valid <= 1'b0;
            hold_user  <= 1'b0;
            hold_data  <= '0;
        end else begin
            hold_valid <= load;
            if (load) begin
                hold_data <= px24;
                hold_user <= (state == ARMED);
            end
        end
    end

    // FIFO storage: {TUSER, TLAST, RGB888}.
    always_ff @(posedge CLK) begin
        if (mem_wr) mem[wr_ptr] <= {hold_user, ~s1_de, hold_data};
    end

    // FIFO pointers and fill count.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({mem_wr, mem_rd})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // AXIS output register; it counts toward FIFO occupancy so total buffering equals FIFO_DEPTH.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            out_valid <= 1'b0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (mem_rd) begin
            out_valid                      <= 1'b1;
            {out_user, out_last, out_data} <= mem[rd_ptr];
        end else if (M_AXIS_TREADY) begin
            out_valid <= 1'b0;
        end
    end

    assign M_AXIS_TDATA  = {8'h00, out_data};
    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TUSER  = out_user;
    assign M_AXIS_TLAST  = out_last;

    // Sticky overflow flag; a new overflow beats a same-cycle clear.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n)  OVERFLOW <= 1'b0;
        else if (ovf_evt) OVERFLOW <= 1'b1;
        else if (CLR_OVF) OVERFLOW <= 1'b0;
    end

    // Geometry counters run in every capture state, including overflow recovery.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pix_cnt      <= '0;
            last_width   <= '0;
            line_cnt     <= '0;
            FRAME_WIDTH  <= '0;
            FRAME_HEIGHT <= '0;
            FRAME_DONE   <= 1'b0;
        end else begin
            FRAME_DONE <= vs_rise;
            if (s1_de) begin
                if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
            end else if (de_prev) begin
                last_width <= pix_cnt;
                pix_cnt    <= '0;
            end
            if (vs_rise) begin
                FRAME_WIDTH  <= last_width;
                FRAME_HEIGHT <= line_cnt;
                line_cnt     <= '0;
            end else if (de_fall && line_cnt != '1) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dso100_rgb565_video_capture.sv
// Bench for dso100_rgb565_video_capture: directed frames with random pixel data and random TREADY,
// checked against a frame-level expectation queue and geometry bookkeeping.
module tb_dso100_rgb565_video_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hd_d;
    logic        hd_de, hd_hs, hd_vs;
    logic [31:0] tdata;
    logic        tvalid, tready, tuser, tlast;
    logic [11:0] fw, fh;
    logic        fdone, ovf, clr_ovf;
    logic [31:0] n_tdata;
    logic        n_tvalid, n_tuser, n_tlast;
    logic [11:0] n_fw, n_fh;
    logic        n_fdone, n_ovf;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ready_mode = 0;      // 0: always ready, 1: always stalled, 2: random
    bit    cap = 0;             // frame is being captured by the design
    bit    sof_pend = 0;
    int    lines_seen = 0, last_w = 0;
    int    exp_fw = 0, exp_fh = 0;
    int    exp_done = 0, done_cnt = 0, done_cnt_n = 0;
    bit    exp_ovf = 0;

    dso100_rgb565_video_capture #(.SYNC_POL(1), .FIFO_DEPTH(16), .CNT_W(12)) dut (
        .CLK(clk), .RST_N(rst_n), .HD_D(hd_d), .HD_DE(hd_de), .HD_HSYNC(hd_hs), .HD_VSYNC(hd_vs),
        .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
        .M_AXIS_TUSER(tuser), .M_AXIS_TLAST(tlast),
        .FRAME_WIDTH(fw), .FRAME_HEIGHT(fh), .FRAME_DONE(fdone), .OVERFLOW(ovf), .CLR_OVF(clr_ovf)
    );

    // Active-low sync copy: sees the inverted syncs, so it must behave identically.
    dso100_rgb565_video_capture #(.SYNC_POL(0), .FIFO_DEPTH(16), .CNT_W(12)) dut_n (
        .CLK(clk), .RST_N(rst_n), .HD_D(hd_d), .HD_DE(hd_de), .HD_HSYNC(~hd_hs), .HD_VSYNC(~hd_vs),
        .M_AXIS_TDATA(n_tdata), .M_AXIS_TVALID(n_tvalid), .M_AXIS_TREADY(1'b1),
        .M_AXIS_TUSER(n_tuser), .M_AXIS_TLAST(n_tlast),
        .FRAME_WIDTH(n_fw), .FRAME_HEIGHT(n_fh), .FRAME_DONE(n_fdone), .OVERFLOW(n_ovf), .CLR_OVF(1'b0)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] expand(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return 32'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic de, input logic [15:0] d, input logic vs);
        @(negedge clk);
        hd_de = de;
        hd_d  = d;
        hd_vs = vs;
        hd_hs = ~de;
    endtask

    task automatic pixel(input logic [15:0] d, input bit last);
        cyc(1'b1, d, 1'b0);
        if (cap) begin
            if (ready_mode == 1 && exp_q.size() >= 16) begin
                cap     = 0;
                exp_ovf = 1;
            end else begin
                exp_q.push_back('{data: expand(d), user: sof_pend, last: last});
                sof_pend = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic line(input int w, input int gap);
        for (int i = 0; i < w; i++) pixel(16'($urandom), i == w - 1);
        idle(gap);
        lines_seen++;
        last_w = w;
    endtask

    task automatic vsync();
        exp_fw = last_w;
        exp_fh = lines_seen;
        lines_seen = 0;
        exp_done++;
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);
        #1;
        chk("frame_done", fdone, 1);
        chk("frame_width", fw, exp_fw);
        chk("frame_height", fh, exp_fh);
        chk("n_frame_done", n_fdone, 1);
        chk("n_frame_width", n_fw, exp_fw);
        chk("n_frame_height", n_fh, exp_fh);
        cyc(1'b0, 16'h0000, 1'b0);
        #1;
        chk("frame_done_1cyc", fdone, 0);
        cap      = 1;
        sof_pend = 1;
        idle(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        idle(4);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        cap = 0; sof_pend = 0; lines_seen = 0; last_w = 0; exp_ovf = 0;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_width", fw, 0);
        chk("rst_height", fh, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", fdone, 0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
    endtask

    // TREADY driver; random mode throttles stalls so the FIFO cannot fill.
    initial forever begin
        @(negedge clk);
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = 1'b0;
            default: tready = (exp_q.size() >= 10) ? 1'b1 : ($urandom_range(0, 2) != 0);
        endcase
    end

    // Beat scoreboard and FRAME_DONE pulse counting.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n === 1'b1 && tvalid === 1'b1 && tready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL extra_beat observed %h expected no beat", tdata);
            end
            if (exp_q.size() > 0) begin
                beat_t e;
                e = exp_q.pop_front();
                chk("tdata", tdata, e.data);
                chk("tuser", tuser, e.user);
                chk("tlast", tlast, e.last);
            end
        end
        if (fdone === 1'b1) done_cnt++;
        if (n_fdone === 1'b1) done_cnt_n++;
    end

    initial begin
        rst_n = 1'b0; hd_d = '0; hd_de = 0; hd_hs = 1; hd_vs = 0; clr_ovf = 0; tready = 1;
        idle(2);
        do_reset();
        chk("idle_tvalid", tvalid, 0);

        // Pixels before the first vsync are discarded.
        line(8, 2);
        line(8, 2);
        idle(6);

        // 4 lines x 8 pixels, continuous ready.
        vsync();
        for (int l = 0; l < 4; l++) line(8, 2);
        idle(6);
        vsync();

        // Colour expansion and first-beat latency.
        idle(6);
        fork
            begin
                pixel(16'hF800, 0);
                pixel(16'h07E0, 0);
                pixel(16'h001F, 0);
                pixel(16'h8410, 1);
                idle(2);
                lines_seen++;
                last_w = 4;
            end
            begin
                @(negedge clk);
                repeat (3) @(negedge clk);
                #1 chk("latency_k3", tvalid, 0);
                @(negedge clk);
                #1 chk("latency_k4", tvalid, 1);
            end
        join
        drain();

        // Overflow: stalled sink, 20-pixel line.
        vsync();
        ready_mode = 1;
        line(20, 4);
        idle(4);
        chk("ovf_set", ovf, exp_ovf);
        line(8, 2);
        ready_mode = 0;
        drain();
        chk("ovf_sticky", ovf, 1);
        vsync();
        line(8, 2);
        line(8, 2);
        drain();
        @(negedge clk) clr_ovf = 1'b1;
        @(negedge clk) clr_ovf = 1'b0;
        #1 chk("ovf_clear", ovf, 0);

        // Random backpressure over a 64 x 16 frame.
        vsync();
        ready_mode = 2;
        for (int l = 0; l < 16; l++) line(64, 6);
        ready_mode = 0;
        drain();
        vsync();

        // Reset mid-line, then no capture until the next vsync.
        for (int i = 0; i < 10; i++) pixel(16'($urandom), 0);
        do_reset();
        line(8, 2);
        idle(6);
        vsync();
        line(8, 2);
        drain();

        chk("done_count", done_cnt, exp_done);
        chk("n_done_count", done_cnt_n, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
